// File: rtl/rgb_pwm_seq.sv
// Power-up sequencer and three-channel PWM generator for the iCE40UP hard RGB LED driver.
// Colour updates are double-buffered and only take effect at a PWM period boundary.
module rgb_pwm_seq #(
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 47,
  parameter int SETTLE_CYCLES = 1200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty0,
  input  logic [PWM_BITS-1:0] duty1,
  input  logic [PWM_BITS-1:0] duty2,
  input  logic                duty_load,
  output logic                curren,
  output logic                rgbleden,
  output logic                pwm0,
  output logic                pwm1,
  output logic                pwm2,
  output logic                ready
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [PW-1:0]       PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]       SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       presc;
  logic [PWM_BITS-1:0] cnt;
  logic [SW-1:0]       settle_cnt;
  logic [PWM_BITS-1:0] pend0, pend1, pend2;
  logic [PWM_BITS-1:0] act0, act1, act2;
  logic                pend_valid;
  logic                in_run, stay_run, tick, wrap;

  assign in_run   = (state == RUN);
  assign stay_run = in_run && (state_nxt == RUN);
  assign tick     = in_run && (presc == PRE_LAST);
  assign wrap     = tick && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE:  if (!enable) state_nxt = IDLE;
               else if (settle_cnt == '0) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sequencing counters: the settle count is only ever loaded from IDLE, so a
  // re-enable always waits the full settle time.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      cnt        <= '0;
      settle_cnt <= '0;
    end else begin
      if (!stay_run) begin
        presc <= '0;
        cnt   <= '0;
      end else if (tick) begin
        presc <= '0;
        cnt   <= cnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (state == IDLE && state_nxt == SETTLE)
        settle_cnt <= SET_LAST;
      else if (state == SETTLE && state_nxt == SETTLE)
        settle_cnt <= settle_cnt - 1'b1;
      else
        settle_cnt <= '0;
    end
  end

  // Duty double buffer: a load that cannot disturb a running period (not in RUN,
  // or coinciding with the wrap) is applied immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend0      <= '0;
      pend1      <= '0;
      pend2      <= '0;
      act0       <= '0;
      act1       <= '0;
      act2       <= '0;
      pend_valid <= 1'b0;
    end else if (duty_load) begin
      pend0 <= duty0;
      pend1 <= duty1;
      pend2 <= duty2;
      if (!in_run || wrap) begin
        act0       <= duty0;
        act1       <= duty1;
        act2       <= duty2;
        pend_valid <= 1'b0;
      end else begin
        pend_valid <= 1'b1;
      end
    end else if (wrap && pend_valid) begin
      act0       <= pend0;
      act1       <= pend1;
      act2       <= pend2;
      pend_valid <= 1'b0;
    end
  end

  // Output stage: registered from the next state so every pin changes in the
  // same cycle the FSM does; PWM lags the counter by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      curren   <= 1'b0;
      rgbleden <= 1'b0;
      ready    <= 1'b0;
      pwm0     <= 1'b0;
      pwm1     <= 1'b0;
      pwm2     <= 1'b0;
    end else begin
      curren   <= (state_nxt != IDLE);
      rgbleden <= (state_nxt == RUN);
      ready    <= (state_nxt == RUN);
      pwm0     <= stay_run && (cnt < act0);
      pwm1     <= stay_run && (cnt < act1);
      pwm2     <= stay_run && (cnt < act2);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_seq.sv
// Directed bench for rgb_pwm_seq: sequencing, duty buffering, enable drop,
// prescaler and reset behaviour with hand-computed expectations.
module tb_rgb_pwm_seq;

  logic       clk = 1'b0;
  logic       rst;
  // Instance 1: PRESCALE=1, SETTLE_CYCLES=4
  logic       en1, load1;
  logic [7:0] d0_1, d1_1, d2_1;
  logic       curren1, rgbleden1, pwm0_1, pwm1_1, pwm2_1, ready1;
  // Instance 2: PRESCALE=3, SETTLE_CYCLES=4
  logic       en2, load2;
  logic [7:0] d0_2, d1_2, d2_2;
  logic       curren2, rgbleden2, pwm0_2, pwm1_2, pwm2_2, ready2;

  int tests = 0;
  int fails = 0;
  int cnt_model = 0;

  always #5 clk = ~clk;

  rgb_pwm_seq #(.PWM_BITS(8), .PRESCALE(1), .SETTLE_CYCLES(4)) u1 (
    .clk(clk), .rst(rst), .enable(en1),
    .duty0(d0_1), .duty1(d1_1), .duty2(d2_1), .duty_load(load1),
    .curren(curren1), .rgbleden(rgbleden1),
    .pwm0(pwm0_1), .pwm1(pwm1_1), .pwm2(pwm2_1), .ready(ready1)
  );

  rgb_pwm_seq #(.PWM_BITS(8), .PRESCALE(3), .SETTLE_CYCLES(4)) u2 (
    .clk(clk), .rst(rst), .enable(en2),
    .duty0(d0_2), .duty1(d1_2), .duty2(d2_2), .duty_load(load2),
    .curren(curren2), .rgbleden(rgbleden2),
    .pwm0(pwm0_2), .pwm1(pwm1_2), .pwm2(pwm2_2), .ready(ready2)
  );

  // Advance one clock; cnt_model tracks u1's PWM counter after the edge.
  task automatic step;
    @(posedge clk);
    #1;
    cnt_model = (cnt_model + 1) % 256;
  endtask

  // Raise enable on u1 and check the 4-cycle settle; leaves u1 freshly in RUN.
  task automatic seq_check(input string name);
    logic [5:0] got, exp;
    en1 = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      exp = (e < 5) ? 6'b100000 : 6'b111000;
      got = {curren1, rgbleden1, ready1, pwm0_1, pwm1_1, pwm2_1};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL %s edge %0d: {curren,rgbleden,ready,pwm0..2} got %b expected %b",
                 name, e, got, exp);
      end
    end
    cnt_model = 0;
  endtask

  // Align to a period start on u1 and count high samples over one full period.
  // Optional loads at counter positions pa/pb with packed {duty2,duty1,duty0}.
  task automatic measure_period(input int pa, input logic [23:0] va,
                                input int pb, input logic [23:0] vb,
                                output int h0, output int h1, output int h2);
    int guard = 0;
    h0 = 0; h1 = 0; h2 = 0;
    while (cnt_model != 0 && guard < 300) begin
      step();
      guard++;
    end
    for (int i = 0; i < 256; i++) begin
      if (i == pa) begin {d2_1, d1_1, d0_1} = va; load1 = 1'b1; end
      if (i == pb) begin {d2_1, d1_1, d0_1} = vb; load1 = 1'b1; end
      step();
      load1 = 1'b0;
      h0 += int'(pwm0_1);
      h1 += int'(pwm1_1);
      h2 += int'(pwm2_1);
    end
  endtask

  task automatic chk_period(input string name, input int h0, input int h1, input int h2,
                            input int e0, input int e1, input int e2);
    tests++;
    if (h0 !== e0 || h1 !== e1 || h2 !== e2) begin
      fails++;
      $display("FAIL %s: high counts pwm0/1/2 got %0d/%0d/%0d expected %0d/%0d/%0d",
               name, h0, h1, h2, e0, e1, e2);
    end
  endtask

  task automatic test_reset;
    logic [5:0] g1, g2;
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; load1 = 1'b0; load2 = 1'b0;
    {d0_1, d1_1, d2_1} = '0;
    {d0_2, d1_2, d2_2} = '0;
    repeat (3) step();
    g1 = {curren1, rgbleden1, ready1, pwm0_1, pwm1_1, pwm2_1};
    g2 = {curren2, rgbleden2, ready2, pwm0_2, pwm1_2, pwm2_2};
    tests++;
    if (g1 !== 6'b0) begin fails++; $display("FAIL reset_u1: outputs got %b expected 000000", g1); end
    tests++;
    if (g2 !== 6'b0) begin fails++; $display("FAIL reset_u2: outputs got %b expected 000000", g2); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sequencing;
    d0_1 = 8'd0; d1_1 = 8'd128; d2_1 = 8'd255; load1 = 1'b1;
    step();
    load1 = 1'b0;
    step();
    seq_check("sequencing");
  endtask

  task automatic test_duty_values;
    int h0, h1, h2;
    measure_period(-1, 24'h0, -1, 24'h0, h0, h1, h2);
    chk_period("duty_0_128_255", h0, h1, h2, 0, 128, 255);
    measure_period(-1, 24'h0, -1, 24'h0, h0, h1, h2);
    tests++;
    if (256 - h2 !== 1) begin
      fails++;
      $display("FAIL duty255_low_count: pwm2 low samples got %0d expected 1", 256 - h2);
    end
  endtask

  task automatic test_buffered_update;
    int h0, h1, h2;
    measure_period(100, {8'd255, 8'd64, 8'd0}, -1, 24'h0, h0, h1, h2);
    chk_period("preload_64_period", h0, h1, h2, 0, 128, 255);
    measure_period(10, {8'd255, 8'd192, 8'd0}, -1, 24'h0, h0, h1, h2);
    chk_period("load192_at10_current", h0, h1, h2, 0, 64, 255);
    measure_period(-1, 24'h0, -1, 24'h0, h0, h1, h2);
    chk_period("load192_next", h0, h1, h2, 0, 192, 255);
    measure_period(20, {8'd255, 8'd100, 8'd0}, 40, {8'd255, 8'd30, 8'd0}, h0, h1, h2);
    chk_period("two_loads_current", h0, h1, h2, 0, 192, 255);
    measure_period(-1, 24'h0, -1, 24'h0, h0, h1, h2);
    chk_period("two_loads_last_wins", h0, h1, h2, 0, 30, 255);
  endtask

  task automatic test_load_on_wrap;
    int h0, h1, h2;
    measure_period(255, {8'd255, 8'd30, 8'd7}, -1, 24'h0, h0, h1, h2);
    chk_period("wrap_load_current", h0, h1, h2, 0, 30, 255);
    measure_period(-1, 24'h0, -1, 24'h0, h0, h1, h2);
    chk_period("wrap_load_next", h0, h1, h2, 7, 30, 255);
    measure_period(-1, 24'h0, -1, 24'h0, h0, h1, h2);
    chk_period("wrap_load_stable", h0, h1, h2, 7, 30, 255);
  endtask

  task automatic test_enable_drop;
    logic [5:0] got;
    int highs, h0, h1, h2;
    repeat (50) step();
    en1 = 1'b0;
    step();
    got = {curren1, rgbleden1, ready1, pwm0_1, pwm1_1, pwm2_1};
    tests++;
    if (got !== 6'b0) begin
      fails++;
      $display("FAIL enable_drop: outputs got %b expected 000000", got);
    end
    step();
    seq_check("reenable");
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      highs += int'(pwm1_1);
    end
    tests++;
    if (highs !== 30) begin
      fails++;
      $display("FAIL reenable_restart_high: pwm1 high samples got %0d expected 30", highs);
    end
    step();
    tests++;
    if (pwm1_1 !== 1'b0) begin
      fails++;
      $display("FAIL reenable_restart_low: pwm1 at position 30 got %b expected 0", pwm1_1);
    end
    measure_period(-1, 24'h0, -1, 24'h0, h0, h1, h2);
    chk_period("reenable_retained", h0, h1, h2, 7, 30, 255);
  endtask

  task automatic test_prescaler;
    int highs0, highs1;
    logic [1:0] got;
    d0_2 = 8'd2; d1_2 = 8'd0; d2_2 = 8'd0; load2 = 1'b1;
    step();
    load2 = 1'b0;
    en2 = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      got = {curren2, rgbleden2};
      tests++;
      if (got !== ((e < 5) ? 2'b10 : 2'b11)) begin
        fails++;
        $display("FAIL presc_settle edge %0d: {curren,rgbleden} got %b expected %b",
                 e, got, (e < 5) ? 2'b10 : 2'b11);
      end
    end
    highs0 = 0; highs1 = 0;
    for (int i = 0; i < 768; i++) begin
      step();
      highs0 += int'(pwm0_2);
      highs1 += int'(pwm1_2);
    end
    tests++;
    if (highs0 !== 6 || highs1 !== 0) begin
      fails++;
      $display("FAIL prescale3_duty2: pwm0/pwm1 highs per 768 clk got %0d/%0d expected 6/0",
               highs0, highs1);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [5:0] g1, g2;
    int h0, h1, h2;
    repeat (17) step();
    rst = 1'b1;
    step();
    g1 = {curren1, rgbleden1, ready1, pwm0_1, pwm1_1, pwm2_1};
    g2 = {curren2, rgbleden2, ready2, pwm0_2, pwm1_2, pwm2_2};
    tests++;
    if (g1 !== 6'b0 || g2 !== 6'b0) begin
      fails++;
      $display("FAIL rst_mid_run: u1 outputs %b u2 outputs %b expected 000000", g1, g2);
    end
    rst = 1'b0;
    seq_check("rst_reenable");
    measure_period(5, {8'd0, 8'd0, 8'd50}, -1, 24'h0, h0, h1, h2);
    chk_period("rst_duties_lost", h0, h1, h2, 0, 0, 0);
    measure_period(-1, 24'h0, -1, 24'h0, h0, h1, h2);
    chk_period("rst_new_load", h0, h1, h2, 50, 0, 0);
  endtask

  initial begin
    test_reset();
    test_sequencing();
    test_duty_values();
    test_buffered_update();
    test_load_on_wrap();
    test_enable_drop();
    test_prescaler();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
